// File: rtl/md_pkg.sv
// Shared encodings, FSM state type and helpers for the multiply/divide unit.
package md_pkg;

    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    localparam int DIV_CYCLES_DEFAULT = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DIV  = 2'b10,
        ST_FIX  = 2'b11
    } md_state_t;

    // Magnitude of a 32-bit operand; raw value when the operation is unsigned.
    function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (32'd0 - v) : v;
    endfunction

endpackage

// File: rtl/md_div_iter.sv
// Restoring magnitude divider: one quotient bit per step, 33-bit trial subtract.
module md_div_iter
    import md_pkg::*;
#(
    parameter int DIV_CYCLES = DIV_CYCLES_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        step,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        last
);

    localparam int CW = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV_CYCLES - 1);

    logic [CW-1:0] cnt_r;
    logic [31:0]   rem_r;
    logic [31:0]   quo_r;
    logic [31:0]   dvs_r;
    logic [32:0]   shift_s;
    logic [32:0]   diff_s;
    logic          last_s;

    assign shift_s = {rem_r, quo_r[31]};
    assign diff_s  = shift_s - {1'b0, dvs_r};
    assign last_s  = (cnt_r == CNT_LAST);

    // Divider state: load operands, then shift/subtract once per step.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {CW{1'b0}};
            rem_r <= 32'd0;
            quo_r <= 32'd0;
            dvs_r <= 32'd0;
        end else if (load) begin
            cnt_r <= {CW{1'b0}};
            rem_r <= 32'd0;
            quo_r <= dividend;
            dvs_r <= divisor;
        end else if (step) begin
            // A borrow out of bit 32 means the trial subtract failed: restore.
            rem_r <= diff_s[32] ? shift_s[31:0] : diff_s[31:0];
            quo_r <= {quo_r[30:0], ~diff_s[32]};
            cnt_r <= last_s ? {CW{1'b0}} : (cnt_r + CW'(1));
        end else begin
            cnt_r <= cnt_r;
            rem_r <= rem_r;
            quo_r <= quo_r;
            dvs_r <= dvs_r;
        end
    end

    assign quotient  = quo_r;
    assign remainder = rem_r;
    assign last      = last_s;

endmodule

// File: rtl/md_ctrl.sv
// Multiply/divide unit: FSM, single-cycle multiplier, divide sign fixup and Hi/Lo.
module md_ctrl
    import md_pkg::*;
#(
    parameter int DIV_CYCLES = DIV_CYCLES_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  md_op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        cancel,
    input  logic        rd_req,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wb_data,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        stall,
    output logic        done
);

    md_state_t   state_r, next_s;
    logic [1:0]  op_r;
    logic [31:0] a_r, b_r, hi_r, lo_r;
    logic        accept_s, busy_s, done_s, stall_s;
    logic [31:0] quo_s, rem_s, div_hi_s, div_lo_s;
    logic        last_s, div_signed_s;
    logic [63:0] ext_a_s, ext_b_s, prod_s;

    assign accept_s     = (state_r == ST_IDLE) && start && !cancel;
    assign div_signed_s = (op_r == MD_DIV);

    md_div_iter #(.DIV_CYCLES(DIV_CYCLES)) u_div (
        .clk       (clk),
        .rst       (rst),
        .load      (accept_s && md_op[1]),
        .step      (state_r == ST_DIV),
        .dividend  (mag32(src_a, md_op == MD_DIV)),
        .divisor   (mag32(src_b, md_op == MD_DIV)),
        .quotient  (quo_s),
        .remainder (rem_s),
        .last      (last_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_s;
        end
    end

    // Next-state logic; a squash only aborts before the commit cycle.
    always_comb begin
        next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    next_s = md_op[1] ? ST_DIV : ST_MUL;
                end else begin
                    next_s = ST_IDLE;
                end
            end
            ST_MUL:  next_s = ST_IDLE;
            ST_DIV: begin
                if (cancel) begin
                    next_s = ST_IDLE;
                end else if (last_s) begin
                    next_s = ST_FIX;
                end else begin
                    next_s = ST_DIV;
                end
            end
            ST_FIX:  next_s = ST_IDLE;
            default: next_s = ST_IDLE;
        endcase
    end

    // Status outputs, all held low while reset is asserted.
    always_comb begin
        busy_s = (state_r != ST_IDLE) && !rst;
        case (state_r)
            ST_MUL:  done_s = !cancel && !rst;
            ST_FIX:  done_s = !rst;
            default: done_s = 1'b0;
        endcase
        stall_s = busy_s && (start || rd_req);
    end

    // Operand latch at accept; divide fixup needs the original signs.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_r <= 2'b00;
            a_r  <= 32'd0;
            b_r  <= 32'd0;
        end else if (accept_s) begin
            op_r <= md_op;
            a_r  <= src_a;
            b_r  <= src_b;
        end else begin
            op_r <= op_r;
            a_r  <= a_r;
            b_r  <= b_r;
        end
    end

    // Multiplier: 64-bit product of sign- or zero-extended operands.
    always_comb begin
        if (op_r == MD_MULT) begin
            ext_a_s = {{32{a_r[31]}}, a_r};
            ext_b_s = {{32{b_r[31]}}, b_r};
        end else begin
            ext_a_s = {32'd0, a_r};
            ext_b_s = {32'd0, b_r};
        end
        prod_s = ext_a_s * ext_b_s;
    end

    // Divide result: zero divisor short-circuits, otherwise restore the signs.
    always_comb begin
        if (b_r == 32'd0) begin
            div_lo_s = 32'hFFFF_FFFF;
            div_hi_s = a_r;
        end else begin
            div_lo_s = (div_signed_s && (a_r[31] ^ b_r[31])) ? (32'd0 - quo_s) : quo_s;
            div_hi_s = (div_signed_s && a_r[31]) ? (32'd0 - rem_s) : rem_s;
        end
    end

    // Hi/Lo registers: unit commit overrides older mthi/mtlo writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_r <= 32'd0;
            lo_r <= 32'd0;
        end else if (done_s) begin
            if (state_r == ST_MUL) begin
                hi_r <= prod_s[63:32];
                lo_r <= prod_s[31:0];
            end else begin
                hi_r <= div_hi_s;
                lo_r <= div_lo_s;
            end
        end else begin
            hi_r <= hi_we ? wb_data : hi_r;
            lo_r <= lo_we ? wb_data : lo_r;
        end
    end

    assign hi    = hi_r;
    assign lo    = lo_r;
    assign busy  = busy_s;
    assign done  = done_s;
    assign stall = stall_s;

endmodule

// File: tb/tb_md_ctrl.sv
// Directed plus randomized checks of md_ctrl against an arithmetic reference model.
module tb_md_ctrl;
    import md_pkg::*;

    localparam int DC = 32;

    logic        clk = 1'b0;
    logic        rst, start, cancel, rd_req, hi_we, lo_we;
    logic [1:0]  md_op;
    logic [31:0] src_a, src_b, wb_data;
    logic [31:0] hi, lo;
    logic        busy, stall, done;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] ref_hi, ref_lo;

    always #5 clk = ~clk;

    md_ctrl #(.DIV_CYCLES(DC)) dut (
        .clk(clk), .rst(rst), .start(start), .md_op(md_op), .src_a(src_a), .src_b(src_b),
        .cancel(cancel), .rd_req(rd_req), .hi_we(hi_we), .lo_we(lo_we), .wb_data(wb_data),
        .hi(hi), .lo(lo), .busy(busy), .stall(stall), .done(done)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Architectural result of one instruction, from plain integer arithmetic.
    function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] mhi, output logic [31:0] mlo);
        longint      sa, sb, q, r, p;
        logic [63:0] pu;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        mhi = 32'd0;
        mlo = 32'd0;
        case (op)
            2'b00: begin p = sa * sb; mhi = p[63:32]; mlo = p[31:0]; end
            2'b01: begin pu = {32'd0, a} * {32'd0, b}; mhi = pu[63:32]; mlo = pu[31:0]; end
            default: begin
                if (b == 32'd0) begin
                    mlo = 32'hFFFF_FFFF; mhi = a;
                end else if (op == 2'b11) begin
                    mlo = a / b; mhi = a % b;
                end else begin
                    q = sa / sb; r = sa % sb;
                    mlo = q[31:0]; mhi = r[31:0];
                end
            end
        endcase
    endfunction

    function automatic logic [31:0] pick();
        logic [31:0] v;
        case ($urandom_range(0, 6))
            0: v = 32'd0;
            1: v = 32'd1;
            2: v = 32'hFFFF_FFFF;
            3: v = 32'h8000_0000;
            4: v = 32'h7FFF_FFFF;
            5: v = 32'($urandom_range(0, 300));
            default: v = $urandom;
        endcase
        return v;
    endfunction

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic rdq, input logic cancel_fix, input string tag);
        int          n;
        logic [31:0] eh, el;
        model(op, a, b, eh, el);
        md_op = op; src_a = a; src_b = b; rd_req = rdq; start = 1'b1;
        #1;
        chk({tag, "_stall_idle"}, 64'(stall), 64'(1'b0));
        tick();
        start = 1'b0;
        n = 1;
        while (!done && n < DC + 10) begin
            if (rdq) chk({tag, "_stall_busy"}, 64'(stall), 64'(1'b1));
            tick();
            n++;
        end
        chk({tag, "_lat"}, 64'(n), 64'(op[1] ? DC + 1 : 1));
        chk({tag, "_busy"}, 64'(busy), 64'(1'b1));
        if (cancel_fix && op[1]) begin
            cancel = 1'b1;
            #1;
            chk({tag, "_done_cancel_fix"}, 64'(done), 64'(1'b1));
        end
        tick();
        cancel = 1'b0; rd_req = 1'b0;
        chk({tag, "_hi"}, 64'(hi), 64'(eh));
        chk({tag, "_lo"}, 64'(lo), 64'(el));
        chk({tag, "_idle"}, 64'({busy, done}), 64'(2'b00));
        ref_hi = eh; ref_lo = el;
    endtask

    initial begin
        int n, dcnt;
        rst = 1'b1; start = 1'b1; cancel = 1'b0; rd_req = 1'b1; hi_we = 1'b1; lo_we = 1'b1;
        md_op = MD_MULT; src_a = 32'd3; src_b = 32'd4; wb_data = 32'hFFFF;
        tick();
        tick();
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        chk("rst_outs", 64'({busy, stall, done}), 64'(3'b000));
        rst = 1'b0; start = 1'b0; rd_req = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        ref_hi = 32'd0; ref_lo = 32'd0;

        run_op(MD_MULT, 32'hFFFF_FFFD, 32'd5, 1'b0, 1'b0, "mult_m3x5");
        run_op(MD_DIVU, 32'd100, 32'd7, 1'b1, 1'b0, "divu_100_7");
        run_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, "div_m7_2");
        run_op(MD_DIV, 32'd9, 32'd0, 1'b0, 1'b1, "div_9_0");
        run_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, "multu_max");
        run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, "div_ovf");

        // mthi mid-divide, then the commit overwrites it.
        md_op = MD_DIVU; src_a = 32'd20; src_b = 32'd3; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (8) tick();
        hi_we = 1'b1; wb_data = 32'hDEAD;
        tick();
        hi_we = 1'b0;
        chk("mthi_busy_hi", 64'(hi), 64'h0000_DEAD);
        chk("mthi_busy_lo", 64'(lo), 64'(ref_lo));
        repeat (23) tick();
        chk("divu_20_3_done", 64'(done), 64'(1'b1));
        tick();
        chk("divu_20_3_hi", 64'(hi), 64'd2);
        chk("divu_20_3_lo", 64'(lo), 64'd6);
        ref_hi = 32'd2; ref_lo = 32'd6;

        // Commit wins over coincident mthi/mtlo.
        md_op = MD_MULT; src_a = 32'd6; src_b = 32'd7; start = 1'b1;
        tick();
        start = 1'b0; hi_we = 1'b1; lo_we = 1'b1; wb_data = 32'h1234;
        tick();
        hi_we = 1'b0; lo_we = 1'b0;
        chk("commit_wins", 64'({hi, lo}), {32'd0, 32'd42});

        // mtlo in idle.
        lo_we = 1'b1; wb_data = 32'hCAFE;
        tick();
        lo_we = 1'b0;
        chk("mtlo_idle", 64'(lo), 64'h0000_CAFE);
        ref_hi = 32'd0; ref_lo = 32'hCAFE;

        // Squashed issue in idle is ignored.
        start = 1'b1; cancel = 1'b1; md_op = MD_DIV;
        tick();
        start = 1'b0; cancel = 1'b0;
        chk("cancel_idle", 64'(busy), 64'(1'b0));

        // Cancel during MUL.
        md_op = MD_MULT; src_a = 32'd5; src_b = 32'd5; start = 1'b1;
        tick();
        start = 1'b0; cancel = 1'b1;
        #1;
        chk("cancel_mul_done", 64'(done), 64'(1'b0));
        tick();
        cancel = 1'b0;
        chk("cancel_mul_hilo", 64'({hi, lo}), {ref_hi, ref_lo});
        chk("cancel_mul_busy", 64'(busy), 64'(1'b0));

        // Cancel at cycle 5 of a divide.
        md_op = MD_DIV; src_a = 32'd50; src_b = 32'd5; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        cancel = 1'b1;
        #1;
        chk("cancel_div_done", 64'(done), 64'(1'b0));
        tick();
        cancel = 1'b0;
        chk("cancel_div_busy", 64'(busy), 64'(1'b0));
        dcnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) dcnt++;
            tick();
        end
        chk("cancel_div_nodone", 64'(dcnt), 64'd0);
        chk("cancel_div_hilo", 64'({hi, lo}), {ref_hi, ref_lo});

        // Start held while busy is not accepted; divide latency unaffected.
        md_op = MD_DIVU; src_a = 32'd1000; src_b = 32'd10; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        md_op = MD_MULT; src_a = 32'd3; src_b = 32'd3; start = 1'b1;
        #1;
        chk("busy_start_stall", 64'(stall), 64'(1'b1));
        repeat (3) tick();
        start = 1'b0;
        n = 9;
        while (!done && n < DC + 10) begin
            tick();
            n++;
        end
        chk("busy_start_lat", 64'(n), 64'(DC + 1));
        tick();
        chk("busy_start_res", 64'({hi, lo}), {32'd0, 32'd100});
        chk("busy_start_idle", 64'(busy), 64'(1'b0));
        ref_hi = 32'd0; ref_lo = 32'd100;

        // Reset at cycle 15 of a divide.
        md_op = MD_DIV; src_a = 32'd77; src_b = 32'd3; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (13) tick();
        rst = 1'b1; rd_req = 1'b1; hi_we = 1'b1; wb_data = 32'h5555;
        #1;
        chk("rst_mid_outs", 64'({busy, stall, done}), 64'(3'b000));
        tick();
        rst = 1'b0; rd_req = 1'b0; hi_we = 1'b0;
        chk("rst_mid_hilo", 64'({hi, lo}), 64'd0);
        chk("rst_mid_busy", 64'(busy), 64'(1'b0));
        dcnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) dcnt++;
            tick();
        end
        chk("rst_mid_nodone", 64'(dcnt), 64'd0);
        ref_hi = 32'd0; ref_lo = 32'd0;

        for (int k = 0; k < 24; k++) begin
            logic [1:0]  rop;
            logic [31:0] ra, rb;
            rop = 2'($urandom_range(0, 3));
            ra = pick();
            rb = pick();
            run_op(rop, ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
